// File: rtl/fetch_stage_if.sv
// Instruction-memory read bus: fetch_stage drives it as master, the synchronous
// instruction memory answers as slave (read data valid the cycle after imem_en).
interface fetch_stage_if #(
  parameter int ADDR_W  = 10,
  parameter int INSTR_W = 32
);
  logic               imem_en;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (output imem_en, output imem_addr, input imem_rdata);
  modport slave  (input imem_en, input imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register with a one-entry skid buffer for stalls.
// Optional performance counters are built only when FETCH_PERF_CNT_EN is defined.
module fetch_stage #(
  parameter int                ADDR_W   = 10,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  fetch_stage_if.master      imem,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [1:0]         instruction_type,
  output logic [4:0]         func,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_bubble_cnt
);

  localparam logic [1:0] ST_RUN       = 2'b00;
  localparam logic [1:0] ST_HOLD      = 2'b10;
  localparam logic [1:0] ST_HOLD_SKID = 2'b11;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  f_pc_q, f_pc_d;
  logic               f_valid_q, f_valid_d;
  logic               sk_valid_q, sk_valid_d;
  logic [INSTR_W-1:0] sk_instr_q, sk_instr_d;
  logic [ADDR_W-1:0]  sk_pc_q, sk_pc_d;
  logic               id_valid_q, id_valid_d;
  logic [INSTR_W-1:0] id_instr_q, id_instr_d;
  logic [ADDR_W-1:0]  id_pc_q, id_pc_d;
  logic [1:0]         state;
  logic               issue;

  // State is not stored: it is fully implied by the stall input and skid occupancy.
  always_comb begin
    state = ST_RUN;
    if (stall) begin
      state = sk_valid_q ? ST_HOLD_SKID : ST_HOLD;
    end
  end

  always_comb begin
    pc_d       = pc_q;
    f_pc_d     = f_pc_q;
    f_valid_d  = f_valid_q;
    sk_valid_d = sk_valid_q;
    sk_instr_d = sk_instr_q;
    sk_pc_d    = sk_pc_q;
    id_valid_d = id_valid_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    issue      = 1'b0;

    if (branch_taken) begin
      // Redirect squashes the in-flight read, the skid entry and IF/ID.
      pc_d       = branch_target;
      f_valid_d  = 1'b0;
      sk_valid_d = 1'b0;
      id_valid_d = 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          issue     = 1'b1;
          f_pc_d    = pc_q;
          pc_d      = pc_q + ADDR_W'(1);
          f_valid_d = 1'b1;
          if (sk_valid_q) begin
            id_valid_d = 1'b1;
            id_instr_d = sk_instr_q;
            id_pc_d    = sk_pc_q;
            sk_valid_d = 1'b0;
          end else begin
            id_valid_d = f_valid_q;
            id_instr_d = imem.imem_rdata;
            id_pc_d    = f_pc_q;
          end
        end
        ST_HOLD: begin
          // The word requested last cycle arrives now; park it rather than lose it.
          if (f_valid_q) begin
            sk_valid_d = 1'b1;
            sk_instr_d = imem.imem_rdata;
            sk_pc_d    = f_pc_q;
          end
          f_valid_d = 1'b0;
        end
        default: begin
          f_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      f_pc_q     <= '0;
      f_valid_q  <= 1'b0;
      sk_valid_q <= 1'b0;
      sk_instr_q <= '0;
      sk_pc_q    <= '0;
      id_valid_q <= 1'b0;
      id_instr_q <= '0;
      id_pc_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      f_pc_q     <= f_pc_d;
      f_valid_q  <= f_valid_d;
      sk_valid_q <= sk_valid_d;
      sk_instr_q <= sk_instr_d;
      sk_pc_q    <= sk_pc_d;
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
    end
  end

  assign imem.imem_en   = rst & issue;
  assign imem.imem_addr = pc_q;

  assign id_valid = id_valid_q;
  assign id_instr = id_instr_q;
  assign id_pc    = id_pc_q;

  // Empty slots are presented as the unused type 2'b11 so control_unit sees a NOP.
  assign instruction_type = id_valid_q ? id_instr_q[31:30] : 2'b11;
  assign func             = id_valid_q ? id_instr_q[29:25] : 5'b00000;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (!branch_taken && !stall && id_valid_d) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
    if (!id_valid_d) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign perf_fetch_cnt  = fetch_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`else
  assign perf_fetch_cnt  = 32'd0;
  assign perf_bubble_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized scoreboard bench for fetch_stage: the driver predicts the program-order
// instruction stream, a monitor checks every new IF/ID entry, bubble and counter.
module tb_fetch_stage;

  localparam int              ADDR_W   = 6;
  localparam int              INSTR_W  = 32;
  localparam logic [ADDR_W-1:0] RESET_PC = 6'd60;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               stall;
  logic               branch_taken;
  logic [ADDR_W-1:0]  branch_target;
  logic               id_valid;
  logic [INSTR_W-1:0] id_instr;
  logic [ADDR_W-1:0]  id_pc;
  logic [1:0]         instruction_type;
  logic [4:0]         func;
  logic [31:0]        perf_fetch_cnt;
  logic [31:0]        perf_bubble_cnt;

  fetch_stage_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) imem_bus ();

  fetch_stage #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(RESET_PC)) dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .imem             (imem_bus),
    .id_valid         (id_valid),
    .id_instr         (id_instr),
    .id_pc            (id_pc),
    .instruction_type (instruction_type),
    .func             (func),
    .perf_fetch_cnt   (perf_fetch_cnt),
    .perf_bubble_cnt  (perf_bubble_cnt)
  );

  always #5 clk = ~clk;

  logic [INSTR_W-1:0] mem [2**ADDR_W];

  always @(posedge clk) begin
    if (imem_bus.imem_en) imem_bus.imem_rdata <= mem[imem_bus.imem_addr];
  end

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];
  logic [ADDR_W-1:0] model_pc;
  logic mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // One clock of stimulus; the model advances the program-order stream at issue time.
  task automatic drive(input logic s, input logic b, input logic [ADDR_W-1:0] tgt);
    exp_t e;
    stall         = s;
    branch_taken  = b;
    branch_target = tgt;
    if (b) begin
      exp_q.delete();
      model_pc = tgt;
    end else if (!s) begin
      e.pc    = model_pc;
      e.instr = mem[model_pc];
      exp_q.push_back(e);
      model_pc = model_pc + 1'b1;
    end
    @(posedge clk);
    #2;
  endtask

  // Monitor: samples 1 time unit after each edge, when inputs still show what that edge saw.
  logic prev_run = 1'b0;
  logic prev_branch = 1'b0;
  int   model_fetch = 0;
  int   model_bubble = 0;

  always begin
    logic run_now;
    exp_t e;
    @(posedge clk);
    #1;
    if (mon_en) begin
      run_now = !stall && !branch_taken;
      if (run_now && id_valid) begin
        model_fetch++;
        if (exp_q.size() == 0) begin
          check("unexpected_instr", 32'(id_pc), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("id_pc", 32'(id_pc), 32'(e.pc));
          check("id_instr", id_instr, e.instr);
          check("instruction_type", 32'(instruction_type), 32'(e.instr[31:30]));
          check("func", 32'(func), 32'(e.instr[29:25]));
          $display("fetch pc=%0d instr=%08h type=%0d func=%0d", id_pc, id_instr, instruction_type, func);
        end
      end
      if (branch_taken)          check("redirect_flush", 32'(id_valid), 32'd0);
      else if (prev_branch)      check("redirect_bubble", 32'(id_valid), 32'd0);
      else if (run_now && prev_run) check("throughput", 32'(id_valid), 32'd1);
      if (!id_valid) begin
        model_bubble++;
        check("bubble_type", 32'(instruction_type), 32'd3);
        check("bubble_func", 32'(func), 32'd0);
      end
      check("imem_en", 32'(imem_bus.imem_en), 32'(!stall && !branch_taken));
      if (imem_bus.imem_en) check("imem_addr", 32'(imem_bus.imem_addr), 32'(model_pc));
`ifdef FETCH_PERF_CNT_EN
      check("perf_fetch_cnt", perf_fetch_cnt, 32'(model_fetch));
      check("perf_bubble_cnt", perf_bubble_cnt, 32'(model_bubble));
`else
      check("perf_fetch_cnt", perf_fetch_cnt, 32'd0);
      check("perf_bubble_cnt", perf_bubble_cnt, 32'd0);
`endif
      prev_run    = run_now;
      prev_branch = branch_taken;
    end
  end

  initial begin
    rst           = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    model_pc      = RESET_PC;
    for (int a = 0; a < 2**ADDR_W; a++) begin
      logic [1:0] ty;
      ty     = 2'($urandom_range(0, 2));
      mem[a] = {ty, 5'($urandom), 19'($urandom), 6'(a)};
    end

    repeat (2) @(posedge clk);
    #1;
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_id_pc", 32'(id_pc), 32'd0);
    check("rst_id_instr", id_instr, 32'd0);
    check("rst_type", 32'(instruction_type), 32'd3);
    check("rst_func", 32'(func), 32'd0);
    check("rst_imem_en", 32'(imem_bus.imem_en), 32'd0);
    check("rst_imem_addr", 32'(imem_bus.imem_addr), 32'(RESET_PC));
    check("rst_perf_fetch", perf_fetch_cnt, 32'd0);
    check("rst_perf_bubble", perf_bubble_cnt, 32'd0);
    @(posedge clk);
    #2;
    rst    = 1'b1;
    mon_en = 1'b1;

    // Free run across the address wrap.
    repeat (12) drive(1'b0, 1'b0, '0);
    // Redirect, then single and long stalls with the skid buffer.
    drive(1'b0, 1'b1, 6'd40);
    repeat (4) drive(1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, 6'd3);
    repeat (4) drive(1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, '0);
    repeat (3) drive(1'b0, 1'b0, '0);
    repeat (4) drive(1'b1, 1'b0, '0);
    repeat (3) drive(1'b0, 1'b0, '0);
    // Redirect while the skid buffer is full.
    drive(1'b1, 1'b0, '0);
    drive(1'b1, 1'b1, 6'd12);
    repeat (4) drive(1'b0, 1'b0, '0);

    for (int i = 0; i < 1500; i++) begin
      logic s, b;
      s = ($urandom_range(0, 99) < 25);
      b = ($urandom_range(0, 99) < 7);
      drive(s, b, 6'($urandom));
    end

    repeat (6) drive(1'b0, 1'b0, '0);
    check("drain_one_in_flight", 32'(exp_q.size()), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the pipelined processor. Issues word addresses to the synchronous instruction memory, captures returned words with their PC, and presents the decoded `instruction_type`/`func` fields directly to `control_unit`. It handles hazard stalls without losing an in-flight read by using a one-entry skid buffer. It handles taken-branch redirects by squashing in-flight work.

## Interface
- `ADDR_W`, 10: instruction word-address width.
- `INSTR_W`, 32: instruction width; `[31:30]` is type, `[29:25]` is func.
- `RESET_PC`, 0: first address fetched after reset.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; one clock, asynchronous assert, active-low.
- `stall`  in  1  hazard unit holds the IF/ID stage.
- `branch_taken`  in  1  redirect request from EX.
- `branch_target`  in  ADDR_W  redirect address.
- `imem_en`  out  1  read enable to the instruction memory.
- `imem_addr`  out  ADDR_W  read address; equals `pc`.
- `imem_rdata`  in  INSTR_W  read data, valid the cycle after `imem_en`.
- `id_valid`  out  1  IF/ID holds a real instruction.
- `id_instr`  out  INSTR_W  IF/ID instruction.
- `id_pc`  out  ADDR_W  IF/ID instruction address.
- `instruction_type`  out  2  to `control_unit`; `id_instr[31:30]`, or `2'b11` when `!id_valid`.
- `func`  out  5  to `control_unit`; `id_instr[29:25]`, or `5'b00000` when `!id_valid`.
- `perf_fetch_cnt`  out  32  words loaded into IF/ID; see Configuration.
- `perf_bubble_cnt`  out  32  cycles with `id_valid=0`; see Configuration.

## Operation
- **Registers**
  - `pc`: next address to issue.
  - `f_pc`, `f_valid`: the address issued last cycle, and whether a word for it is still expected.
  - IF/ID register: `id_valid`, `id_instr`, `id_pc`.
  - Skid buffer: `sk_valid`, `sk_instr`, `sk_pc`.
- **Reset** (`rst=0`):
  - `pc=RESET_PC`.
  - `f_valid=0`, `sk_valid=0`, `id_valid=0`.
  - `id_instr=0`, `id_pc=0`.
  - Counters cleared.
  - `imem_en=0` while `rst` is low.
- **Bubble encoding.** Type `2'b11` is unused by the ISA; `control_unit` decodes it as a NOP (no write, no jump). Bubbles must never reach `control_unit` as `2'b00` (SI).
- **State machine.** State is derived from `{stall, sk_valid}`.
  - **RUN** (`stall=0`):
    - Drive `imem_en=1`; on the edge, `f_pc<=pc`, `pc<=pc+1`, `f_valid<=1`.
    - If `sk_valid`: IF/ID loads the skid entry (valid=1) and `sk_valid<=0`.
    - Otherwise: IF/ID loads `{f_valid, imem_rdata, f_pc}`.
  - **HOLD** (`stall=1`, `sk_valid=0`):
    - `imem_en=0`; `pc` and IF/ID hold.
    - If `f_valid`: the skid buffer captures `{imem_rdata, f_pc}` and `sk_valid<=1`.
    - `f_valid<=0`.
    - Next state is HOLD_SKID if a word was captured, else HOLD.
  - **HOLD_SKID** (`stall=1`, `sk_valid=1`):
    - Everything holds; `imem_en=0`.
    - `f_valid` is already 0, so no word is in flight.
  - Leaving either hold state with `stall=0` returns to RUN.
- **Redirect** (`branch_taken=1`) overrides `stall` and all of the above:
  - `pc<=branch_target`.
  - `f_valid<=0`, `sk_valid<=0`, `id_valid<=0`.
  - `imem_en=0` that cycle.
- **Address wrap.** `pc+1` wraps modulo 2^ADDR_W; no error is flagged.
- **Ordering.** Program order is preserved in every case; no word is ever duplicated or dropped except by redirect.

## Timing
- **Sequential fetch latency.** Address is issued in cycle N, data returns in N+1, and IF/ID is valid from edge N+1 onward (i.e. during N+2).
- **First instruction after reset.** With `rst` released before edge E0, `RESET_PC` is issued at E0 and `id_valid=1` with `id_pc=RESET_PC` after E1.
- **Throughput.** One instruction per cycle while `stall=0` and no redirect.
- **Redirect penalty.** Redirect sampled at edge T:
  - target issued at T+1;
  - `id_pc=branch_target`, `id_valid=1` after T+2;
  - exactly two bubbles, visible after T and T+1.
- **Stall release.** The instruction after a stalled one appears on the first edge with `stall=0`; there are no extra bubbles when the skid buffer was filled.
- **Outputs.** `instruction_type`/`func` are combinational from the IF/ID register only, with no path from `imem_rdata`. `imem_addr` is combinational from `pc`.

## Configuration
- **With `FETCH_PERF_CNT_EN` defined:**
  - `perf_fetch_cnt` increments on each edge where IF/ID loads with valid=1.
  - `perf_bubble_cnt` increments on each edge where `id_valid` is 0 after the edge.
  - Both wrap at 2^32 and clear on reset.
- **Without it:** both ports are present and tied to 0, and no counter logic is generated.

## Test plan
- **Reset then free run.**
  - Stimulus: `RESET_PC=0`, memory word k = `{2'b10, k[4:0], …}`, `rst` low for 3 cycles then high.
  - Required response: `id_pc` = 0,1,2,3 on consecutive cycles and `func` follows k; `instruction_type=2'b11` before the first valid.
- **Single-cycle stall.**
  - Stimulus: `stall=1` for 1 cycle while `id_pc=5`.
  - Required response: `id_pc` is 5,5,6,7 with no gap, and the skid buffer is used once.
- **Long stall.**
  - Stimulus: `stall=1` for 4 cycles while `id_pc=5`.
  - Required response: `imem_en=0` during cycles 2–4 and `id_pc` holds 5. After release, 6 then 7 with no duplicates.
- **Redirect.**
  - Stimulus: `branch_taken=1`, `branch_target=40` while `id_pc=9`.
  - Required response: two cycles of `instruction_type=2'b11`, then `id_pc` is 40,41.
- **Redirect during stall with full skid.**
  - Stimulus: `stall=1`, then `branch_taken=1`, `branch_target=12` in the same cycle.
  - Required response: skid discarded; next valid `id_pc=12` two edges later.
- **Wrap and counters.**
  - Stimulus: `ADDR_W=4`, `RESET_PC=14`, `FETCH_PERF_CNT_EN` defined; run 6 cycles.
  - Required response: `id_pc` is 14,15,0,1,… Reading just after the edge that loads `id_pc=1`: `perf_fetch_cnt=4` and `perf_bubble_cnt=1` (the single pre-first-valid bubble).
